// File: rtl/mips_pkg.sv
// Shared encodings for the miniMIPS execute sequencer: ALU op codes, opcode/funct
// values, FSM states, instruction field positions and the instruction decoder.
package mips_pkg;

  typedef enum logic [2:0] {
    AluAdd  = 3'b000,
    AluXor  = 3'b001,
    AluSub  = 3'b010,
    AluMult = 3'b011,
    AluSlt  = 3'b100,
    AluNor  = 3'b101,
    AluAnd  = 3'b110,
    AluOr   = 3'b111
  } alu_op_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpXori  = 6'b001110;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpBeq   = 6'b000100;

  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnXor  = 6'b100110;
  localparam logic [5:0] FnSub  = 6'b100010;
  localparam logic [5:0] FnMult = 6'b011000;
  localparam logic [5:0] FnSlt  = 6'b101010;
  localparam logic [5:0] FnNor  = 6'b100111;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;

  typedef enum logic [1:0] {
    StIdle,
    StDecode,
    StExec,
    StWb
  } state_e;

  localparam int unsigned OpcMsb = 31;
  localparam int unsigned OpcLsb = 26;
  localparam int unsigned RsMsb  = 25;
  localparam int unsigned RsLsb  = 21;
  localparam int unsigned RtMsb  = 20;
  localparam int unsigned RtLsb  = 16;
  localparam int unsigned RdMsb  = 15;
  localparam int unsigned RdLsb  = 11;
  localparam int unsigned ImmMsb = 15;
  localparam int unsigned ImmLsb = 0;
  localparam int unsigned FnMsb  = 5;
  localparam int unsigned FnLsb  = 0;

  typedef struct packed {
    logic       legal;
    logic       wr_en;
    logic       is_beq;
    logic       use_imm;
    logic       sign_ext;
    logic [4:0] dest;
    alu_op_e    op;
  } decode_t;

  function automatic decode_t decode(input logic [31:0] instr);
    decode_t d;
    d.legal    = 1'b1;
    d.wr_en    = 1'b1;
    d.is_beq   = 1'b0;
    d.use_imm  = 1'b1;
    d.sign_ext = 1'b0;
    d.dest     = instr[RtMsb:RtLsb];
    d.op       = AluAdd;
    case (instr[OpcMsb:OpcLsb])
      OpRtype: begin
        d.use_imm = 1'b0;
        d.dest    = instr[RdMsb:RdLsb];
        case (instr[FnMsb:FnLsb])
          FnAdd:   d.op = AluAdd;
          FnXor:   d.op = AluXor;
          FnSub:   d.op = AluSub;
          FnMult:  d.op = AluMult;
          FnSlt:   d.op = AluSlt;
          FnNor:   d.op = AluNor;
          FnAnd:   d.op = AluAnd;
          FnOr:    d.op = AluOr;
          default: d.legal = 1'b0;
        endcase
      end
      OpAddi: d.sign_ext = 1'b1;
      OpXori: d.op = AluXor;
      OpAndi: d.op = AluAnd;
      OpOri:  d.op = AluOr;
      OpSlti: begin
        d.op       = AluSlt;
        d.sign_ext = 1'b1;
      end
      OpBeq: begin
        d.op      = AluSub;
        d.use_imm = 1'b0;
        d.wr_en   = 1'b0;
        d.is_beq  = 1'b1;
      end
      default: d.legal = 1'b0;
    endcase
    // Unsupported encodings present a neutral add and never write back.
    if (!d.legal) begin
      d.wr_en = 1'b0;
      d.op    = AluAdd;
    end
    return d;
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports, a debug read port and one
// synchronous write port; register 0 always reads as zero.
module mips_regfile (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_a_i,
  output logic [31:0] rdata_a_o,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_b_o,
  input  logic [4:0]  dbg_addr_i,
  output logic [31:0] dbg_data_o
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = (raddr_a_i == 5'd0)  ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o  = (raddr_b_i == 5'd0)  ? '0 : regs_q[raddr_b_i];
  assign dbg_data_o = (dbg_addr_i == 5'd0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_exec_unit.sv
// Non-pipelined execute sequencer: accepts one instruction, reads operands, drives the
// external ALU, captures its result and writes it back over IDLE/DECODE/EXEC/WB.
module alu_exec_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [2:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_res,
  input  logic        alu_zero,
  output logic        done,
  output logic [31:0] wb_data,
  output logic        branch_taken,
  output logic        illegal,
  output logic [31:0] pc,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  decode_t     dec_q, dec_d, dec;
  alu_op_e     alu_op_q, alu_op_d;
  logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        branch_q, branch_d, illegal_q, illegal_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] rs_data, rt_data, imm_ext;
  logic [15:0] imm;

  assign dec     = decode(instr_q);
  assign imm     = instr_q[ImmMsb:ImmLsb];
  assign imm_ext = dec.sign_ext ? {{16{imm[15]}}, imm} : {16'h0000, imm};

  mips_regfile u_regfile (
    .clk_i      (clk),
    .rst_i      (rst),
    .we_i       ((state_q == StWb) && dec_q.wr_en),
    .waddr_i    (dec_q.dest),
    .wdata_i    (wb_data_q),
    .raddr_a_i  (instr_q[RsMsb:RsLsb]),
    .rdata_a_o  (rs_data),
    .raddr_b_i  (instr_q[RtMsb:RtLsb]),
    .rdata_b_o  (rt_data),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    dec_d     = dec_q;
    alu_op_d  = alu_op_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    wb_data_d = wb_data_q;
    branch_d  = branch_q;
    illegal_d = illegal_q;
    pc_d      = pc_q;
    unique case (state_q)
      StIdle: begin
        if (instr_valid) begin
          state_d = StDecode;
          instr_d = instr;
        end
      end
      StDecode: begin
        state_d  = StExec;
        dec_d    = dec;
        alu_op_d = dec.op;
        alu_a_d  = dec.legal ? rs_data : '0;
        alu_b_d  = !dec.legal ? '0 : (dec.use_imm ? imm_ext : rt_data);
      end
      StExec: begin
        // Retirement results and pc are registered here so they line up with done in WB.
        state_d   = StWb;
        wb_data_d = dec_q.wr_en ? alu_res : '0;
        branch_d  = dec_q.is_beq & alu_zero;
        illegal_d = ~dec_q.legal;
        pc_d      = pc_q + 32'd4;
      end
      StWb: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      instr_q   <= '0;
      dec_q     <= '0;
      alu_op_q  <= AluAdd;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      wb_data_q <= '0;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
      pc_q      <= RESET_PC;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      dec_q     <= dec_d;
      alu_op_q  <= alu_op_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      wb_data_q <= wb_data_d;
      branch_q  <= branch_d;
      illegal_q <= illegal_d;
      pc_q      <= pc_d;
    end
  end

  assign instr_ready  = (state_q == StIdle);
  assign done         = (state_q == StWb);
  assign alu_op       = alu_op_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign wb_data      = wb_data_q;
  assign branch_taken = branch_q;
  assign illegal      = illegal_q;
  assign pc           = pc_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: provides the ALU, runs directed and random instruction
// streams, and compares every cycle against an instruction-level model.
module tb_alu_exec_unit;

  localparam logic [5:0] OpAddi = 6'b001000, OpXori = 6'b001110, OpAndi = 6'b001100;
  localparam logic [5:0] OpOri  = 6'b001101, OpSlti = 6'b001010, OpBeq  = 6'b000100;
  localparam logic [5:0] FnAdd  = 6'b100000, FnXor  = 6'b100110, FnSub  = 6'b100010;
  localparam logic [5:0] FnMult = 6'b011000, FnSlt  = 6'b101010, FnNor  = 6'b100111;
  localparam logic [5:0] FnAnd  = 6'b100100, FnOr   = 6'b100101;

  logic        clk = 1'b0;
  logic        rst, instr_valid, instr_ready;
  logic [31:0] instr;
  logic [2:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_res;
  logic        alu_zero, done;
  logic [31:0] wb_data;
  logic        branch_taken, illegal;
  logic [31:0] pc;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_exec_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .alu_op       (alu_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_res      (alu_res),
    .alu_zero     (alu_zero),
    .done         (done),
    .wb_data      (wb_data),
    .branch_taken (branch_taken),
    .illegal      (illegal),
    .pc           (pc),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a ^ b;
      3'b010:  return a - b;
      3'b011:  return a * b;
      3'b100:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b101:  return ~(a | b);
      3'b110:  return a & b;
      default: return a | b;
    endcase
  endfunction

  assign alu_res  = alu_fn(alu_op, alu_a, alu_b);
  assign alu_zero = (alu_res == 32'd0);

  typedef struct packed {
    logic        legal;
    logic        wr;
    logic        beq;
    logic [4:0]  dest;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } exp_t;

  // Architectural meaning of one instruction given its two source register values.
  function automatic exp_t model_exec(input logic [31:0] w, input logic [31:0] rs_v,
                                      input logic [31:0] rt_v);
    exp_t e;
    logic [15:0] imm;
    imm     = w[15:0];
    e.legal = 1'b1;
    e.wr    = 1'b1;
    e.beq   = 1'b0;
    e.dest  = w[20:16];
    e.op    = 3'b000;
    e.a     = rs_v;
    e.b     = {16'h0000, imm};
    if (w[31:26] == 6'b000000) begin
      e.dest = w[15:11];
      e.b    = rt_v;
      case (w[5:0])
        FnAdd:   e.op = 3'b000;
        FnXor:   e.op = 3'b001;
        FnSub:   e.op = 3'b010;
        FnMult:  e.op = 3'b011;
        FnSlt:   e.op = 3'b100;
        FnNor:   e.op = 3'b101;
        FnAnd:   e.op = 3'b110;
        FnOr:    e.op = 3'b111;
        default: e.legal = 1'b0;
      endcase
    end else begin
      case (w[31:26])
        OpAddi:  begin e.op = 3'b000; e.b = {{16{imm[15]}}, imm}; end
        OpXori:  e.op = 3'b001;
        OpAndi:  e.op = 3'b110;
        OpOri:   e.op = 3'b111;
        OpSlti:  begin e.op = 3'b100; e.b = {{16{imm[15]}}, imm}; end
        OpBeq:   begin e.op = 3'b010; e.b = rt_v; e.wr = 1'b0; e.beq = 1'b1; end
        default: e.legal = 1'b0;
      endcase
    end
    if (!e.legal) begin
      e.wr  = 1'b0;
      e.op  = 3'b000;
      e.res = 32'd0;
    end else begin
      e.res = alu_fn(e.op, e.a, e.b);
    end
    return e;
  endfunction

  function automatic logic [31:0] r_type(input logic [5:0] fn, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [4:0] rt);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rt,
                                         input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] fns [8];
    logic [5:0] ops [6];
    logic [4:0] rd, rs, rt;
    int k;
    fns = '{FnAdd, FnXor, FnSub, FnMult, FnSlt, FnNor, FnAnd, FnOr};
    ops = '{OpAddi, OpXori, OpAndi, OpOri, OpSlti, OpBeq};
    rd  = 5'($urandom_range(0, 7));
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    k   = $urandom_range(0, 14);
    if (k < 8) return r_type(fns[k], rd, rs, rt);
    if (k < 14) return i_type(ops[k-8], rt, rs, 16'($urandom));
    return $urandom;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state, owned by the model process.
  logic [31:0] m_regs [32];
  logic [31:0] m_pc, m_a, m_b, m_wb;
  logic [2:0]  m_op;
  logic        m_ab_known, m_wb_known, m_br, m_ill, m_busy, m_done;
  int          m_age;
  exp_t        m_cur;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pc = 32'd0; m_op = 3'd0; m_a = 32'd0; m_b = 32'd0; m_ab_known = 1'b1;
        m_wb = 32'd0; m_wb_known = 1'b1; m_br = 1'b0; m_ill = 1'b0;
        m_busy = 1'b0; m_done = 1'b0; m_age = 0;
      end else begin
        m_done = 1'b0;
        if (m_busy) begin
          m_age++;
          if (m_age == 1) begin
            m_op = m_cur.op; m_a = m_cur.a; m_b = m_cur.b; m_ab_known = m_cur.legal;
          end else if (m_age == 2) begin
            m_done     = 1'b1;
            m_pc       = m_pc + 32'd4;
            m_wb       = m_cur.wr ? m_cur.res : 32'd0;
            m_wb_known = !m_cur.beq;
            m_br       = m_cur.beq && (m_cur.res == 32'd0);
            m_ill      = !m_cur.legal;
          end else begin
            if (m_cur.wr && m_cur.dest != 5'd0) m_regs[m_cur.dest] = m_cur.res;
            m_busy = 1'b0;
          end
        end else if (instr_valid) begin
          m_cur  = model_exec(instr, m_regs[instr[25:21]], m_regs[instr[20:16]]);
          m_busy = 1'b1;
          m_age  = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
        chk("instr_ready", {31'd0, instr_ready}, {31'd0, !m_busy});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("pc", pc, m_pc);
        chk("alu_op", {29'd0, alu_op}, {29'd0, m_op});
        if (m_ab_known) begin
          chk("alu_a", alu_a, m_a);
          chk("alu_b", alu_b, m_b);
        end
        if (m_wb_known) chk("wb_data", wb_data, m_wb);
        chk("branch_taken", {31'd0, branch_taken}, {31'd0, m_br});
        chk("illegal", {31'd0, illegal}, {31'd0, m_ill});
        chk("dbg_data", dbg_data, m_regs[dbg_addr]);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    dbg_addr = 5'($urandom);
  endtask

  task automatic issue(input logic [31:0] w, output logic [31:0] wb, output logic br,
                       output logic ill, output int lat);
    bit ok;
    int n;
    instr_valid = 1'b1;
    instr       = w;
    ok          = 1'b0;
    n           = 0;
    while (n < 10 && !ok) begin
      ok = instr_ready;
      tick();
      n++;
    end
    chk("accepted", {31'd0, ok}, 32'd1);
    instr_valid = 1'b0;
    instr       = $urandom;
    lat         = 0;
    ok          = 1'b0;
    while (lat < 8 && !ok) begin
      tick();
      lat++;
      ok = done;
    end
    chk("done_seen", {31'd0, ok}, 32'd1);
    wb  = wb_data;
    br  = branch_taken;
    ill = illegal;
  endtask

  logic [31:0] wb;
  logic        br, ill;
  int          lat, cnt;
  bit          seen;

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = 32'd0; dbg_addr = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst instr_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst pc", pc, 32'd0);
    chk("rst alu_op", {29'd0, alu_op}, 32'd0);
    chk("rst alu_a", alu_a, 32'd0);
    chk("rst alu_b", alu_b, 32'd0);
    chk("rst wb_data", wb_data, 32'd0);
    chk("rst flags", {30'd0, branch_taken, illegal}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      chk("rst dbg_data", dbg_data, 32'd0);
    end
    chk_en = 1'b1;
    tick();

    // addi/add chain
    issue(i_type(OpAddi, 5'd1, 5'd0, 16'd13), wb, br, ill, lat);
    chk("addi r1 wb", wb, 32'd13);
    chk("latency", lat, 32'd2);
    issue(i_type(OpAddi, 5'd2, 5'd0, 16'd12), wb, br, ill, lat);
    chk("addi r2 wb", wb, 32'd12);
    issue(r_type(FnAdd, 5'd3, 5'd1, 5'd2), wb, br, ill, lat);
    chk("add r3 wb", wb, 32'd25);
    chk("add alu_op", {29'd0, alu_op}, 32'd0);
    chk("pc after 3", pc, 32'd12);

    // build r4=0x8000000D, r5=0x8000000F
    issue(i_type(OpOri, 5'd8, 5'd0, 16'h8000), wb, br, ill, lat);
    issue(i_type(OpOri, 5'd9, 5'd0, 16'h0100), wb, br, ill, lat);
    issue(r_type(FnMult, 5'd9, 5'd9, 5'd9), wb, br, ill, lat);
    chk("mult r9", wb, 32'h0001_0000);
    issue(r_type(FnMult, 5'd10, 5'd8, 5'd9), wb, br, ill, lat);
    chk("mult r10", wb, 32'h8000_0000);
    issue(i_type(OpOri, 5'd4, 5'd10, 16'h000D), wb, br, ill, lat);
    chk("ori r4", wb, 32'h8000_000D);
    issue(i_type(OpOri, 5'd5, 5'd10, 16'h000F), wb, br, ill, lat);
    issue(r_type(FnSub, 5'd6, 5'd4, 5'd5), wb, br, ill, lat);
    chk("sub r6", wb, 32'hFFFF_FFFE);
    issue(r_type(FnSlt, 5'd7, 5'd4, 5'd5), wb, br, ill, lat);
    chk("slt r7", wb, 32'd1);
    chk("slt alu_op", {29'd0, alu_op}, 32'd4);
    issue(i_type(OpSlti, 5'd11, 5'd0, 16'hFFFF), wb, br, ill, lat);
    chk("slti neg imm", wb, 32'd0);

    // beq
    issue(i_type(OpBeq, 5'd1, 5'd1, 16'd0), wb, br, ill, lat);
    chk("beq equal", {31'd0, br}, 32'd1);
    issue(i_type(OpBeq, 5'd2, 5'd1, 16'd0), wb, br, ill, lat);
    chk("beq unequal", {31'd0, br}, 32'd0);
    tick();
    dbg_addr = 5'd1;
    #1;
    chk("r1 after beq", dbg_data, 32'd13);

    // illegal encodings and register 0
    issue({6'b111111, 26'($urandom)}, wb, br, ill, lat);
    chk("illegal opc", {31'd0, ill}, 32'd1);
    chk("illegal wb", wb, 32'd0);
    chk("illegal alu_op", {29'd0, alu_op}, 32'd0);
    issue(r_type(6'b111111, 5'd3, 5'd1, 5'd2), wb, br, ill, lat);
    chk("illegal funct", {31'd0, ill}, 32'd1);
    issue(r_type(FnAdd, 5'd0, 5'd1, 5'd2), wb, br, ill, lat);
    chk("add r0 legal", {31'd0, ill}, 32'd0);
    tick();
    dbg_addr = 5'd0;
    #1;
    chk("r0 stays 0", dbg_data, 32'd0);
    dbg_addr = 5'd3;
    #1;
    chk("r3 unchanged", dbg_data, 32'd25);

    // instr_valid held high: one accept every 4 cycles
    instr_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      instr = rand_instr();
      if (instr_ready) cnt++;
      tick();
    end
    chk("accepts in 40 cycles", cnt, 32'd10);
    instr_valid = 1'b0;
    repeat (4) tick();

    // random stream
    for (int i = 0; i < 200; i++) begin
      issue(rand_instr(), wb, br, ill, lat);
      chk("latency", lat, 32'd2);
      repeat ($urandom_range(0, 2)) tick();
    end
    tick();

    // reset while in EXEC
    chk("idle before abort", {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1;
    instr = r_type(FnAdd, 5'd12, 5'd1, 5'd2);
    tick();
    instr_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen |= done;
      tick();
    end
    chk("no done after abort", {31'd0, seen}, 32'd0);
    chk("pc after abort", pc, 32'd0);
    dbg_addr = 5'd12;
    #1;
    chk("r12 after abort", dbg_data, 32'd0);
    dbg_addr = 5'd1;
    #1;
    chk("r1 after abort", dbg_data, 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
